serial_subtractor: RTL and testbench

Parametrised multi-cycle subtractor computing `diff = a - b - borr_in` over WIDTH-bit operands, STEP bits per clock, least-significant slice first. It extends the single-bit half subtractor to a full N-bit borrow chain with a registered borrow between slices. Valid/ready handshakes on input and output let it sit between a request source and a result consumer in the arithmetic datapath. It is intended for area-constrained paths where a full-width combinational borrow chain is too large or too slow.

---
 rtl/serial_subtractor.sv | 123 ++++++++++++
 tb/tb_serial_subtractor.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - borr_in, STEP bits per clock, LSB slice first,
// with a registered borrow between slices and valid/ready handshakes on both sides.
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borr_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borr,
    output logic             zero
);

    localparam int N  = WIDTH / STEP;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 1 || STEP < 1 || STEP > WIDTH || (WIDTH % STEP) != 0) begin : g_bad_params
            $error("serial_subtractor: need 1 <= STEP <= WIDTH and WIDTH %% STEP == 0");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CW-1:0]    k;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             borr_run;
    logic [STEP:0]    slice;
    logic [WIDTH-1:0] diff_next;
    logic             last;

    // Slice k difference at STEP+1 bits; the top bit is the borrow out of the slice.
    always_comb begin
        slice     = {1'b0, a_r[k*STEP +: STEP]} - {1'b0, b_r[k*STEP +: STEP]}
                  - {{STEP{1'b0}}, borr_run};
        diff_next = diff;
        diff_next[k*STEP +: STEP] = slice[STEP-1:0];
        last      = (k == CW'(N - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k        <= '0;
            a_r      <= '0;
            b_r      <= '0;
            borr_run <= 1'b0;
            diff     <= '0;
            borr     <= 1'b0;
            zero     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r      <= a;
                        b_r      <= b;
                        borr_run <= borr_in;
                        k        <= '0;
                    end
                end
                RUN: begin
                    diff     <= diff_next;
                    borr_run <= slice[STEP];
                    if (last) begin
                        borr <= slice[STEP];
                        zero <= (diff_next == '0);
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: four parameterisations driven in lockstep,
// results compared against an integer-arithmetic reference of a - b - borr_in.
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        borr_in = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;

    logic        rdy0, rdy1, rdy2, rdy3;
    logic        vld0, vld1, vld2, vld3;
    logic        brw0, brw1, brw2, brw3;
    logic        zr0, zr1, zr2, zr3;
    logic [7:0]  df0, df1, df2;
    logic [15:0] df3;
    logic [3:0]  rdy, vld;

    int tests = 0;
    int fails = 0;

    assign rdy = {rdy3, rdy2, rdy1, rdy0};
    assign vld = {vld3, vld2, vld1, vld0};

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8), .STEP(1)) u_w8s1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
        .a(a[7:0]), .b(b[7:0]), .borr_in(borr_in), .out_valid(vld0),
        .out_ready(out_ready), .diff(df0), .borr(brw0), .zero(zr0));

    serial_subtractor #(.WIDTH(8), .STEP(4)) u_w8s4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
        .a(a[7:0]), .b(b[7:0]), .borr_in(borr_in), .out_valid(vld1),
        .out_ready(out_ready), .diff(df1), .borr(brw1), .zero(zr1));

    serial_subtractor #(.WIDTH(8), .STEP(8)) u_w8s8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2),
        .a(a[7:0]), .b(b[7:0]), .borr_in(borr_in), .out_valid(vld2),
        .out_ready(out_ready), .diff(df2), .borr(brw2), .zero(zr2));

    serial_subtractor #(.WIDTH(16), .STEP(2)) u_w16s2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy3),
        .a(a), .b(b), .borr_in(borr_in), .out_valid(vld3),
        .out_ready(out_ready), .diff(df3), .borr(brw3), .zero(zr3));

    // Reference: plain signed arithmetic on the masked operands.
    function automatic void ref_sub(input int w, input logic [15:0] x, input logic [15:0] y,
                                    input logic bi, output logic [15:0] d, output logic bo);
        longint m;
        longint r;
        m  = (longint'(1) << w) - 1;
        r  = (longint'(x) & m) - (longint'(y) & m) - longint'(bi);
        bo = (r < 0);
        d  = 16'(r & m);
    endfunction

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            tests++;
            if ((rdy & vld) !== 4'h0) begin
                fails++;
                $display("FAIL ready_valid_overlap got rdy=%b vld=%b want no common bit", rdy, vld);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic run_main(input logic [7:0] x, input logic [7:0] y, input logic bi, input string name);
        logic [15:0] ed;
        logic        eb;
        int          lat;
        ref_sub(8, {8'h00, x}, {8'h00, y}, bi, ed, eb);
        @(negedge clk);
        a = {8'h00, x}; b = {8'h00, y}; borr_in = bi; in_valid = 1'b1; out_ready = 1'b1;
        tests++;
        if (rdy0 !== 1'b1) begin fails++; $display("FAIL %s_ready got %b want 1", name, rdy0); end
        @(posedge clk); #1;
        in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); borr_in = 1'($urandom);
        lat = 0;
        while (vld0 !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        tests++;
        if (lat !== 8) begin fails++; $display("FAIL %s_latency got %0d want 8", name, lat); end
        tests++;
        if (df0 !== ed[7:0]) begin fails++; $display("FAIL %s_diff got %h want %h", name, df0, ed[7:0]); end
        tests++;
        if (brw0 !== eb) begin fails++; $display("FAIL %s_borr got %b want %b", name, brw0, eb); end
        tests++;
        if (zr0 !== (ed[7:0] == 8'h00)) begin
            fails++; $display("FAIL %s_zero got %b want %b", name, zr0, ed[7:0] == 8'h00);
        end
        @(posedge clk); #1;
        tests++;
        if (rdy0 !== 1'b1 || vld0 !== 1'b0) begin
            fails++; $display("FAIL %s_consumed got rdy=%b vld=%b want rdy=1 vld=0", name, rdy0, vld0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        #12;
        tests++;
        if (rdy !== 4'hF || vld !== 4'h0) begin
            fails++; $display("FAIL reset_hold got rdy=%b vld=%b want rdy=1111 vld=0000", rdy, vld);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (rdy !== 4'hF || vld !== 4'h0) begin
            fails++; $display("FAIL reset_release got rdy=%b vld=%b want rdy=1111 vld=0000", rdy, vld);
        end
        tests++;
        if (df0 !== 8'h00 || df3 !== 16'h0000 || brw0 !== 1'b0 || zr0 !== 1'b0) begin
            fails++; $display("FAIL reset_outputs got diff=%h diff16=%h borr=%b zero=%b want all 0", df0, df3, brw0, zr0);
        end
    endtask

    task automatic test_basic();
        run_main(8'h05, 8'h03, 1'b0, "basic");
    endtask

    task automatic test_borrow();
        run_main(8'h03, 8'h05, 1'b0, "wrap");
        run_main(8'h00, 8'h00, 1'b1, "borrow_in");
        run_main(8'hA5, 8'hA5, 1'b0, "equal_zero");
    endtask

    task automatic test_sweep();
        int          ns[4] = '{8, 2, 1, 8};
        int          ws[4] = '{8, 8, 8, 16};
        logic [3:0]  got;
        logic [15:0] ed, dsel;
        logic        eb, bsel, zsel;
        logic [15:0] xa, xb;
        logic        xi;
        int          c;
        out_ready = 1'b1;
        for (int it = 0; it < 1000; it++) begin
            @(negedge clk);
            tests++;
            if (rdy !== 4'hF) begin fails++; $display("FAIL sweep_idle got rdy=%b want 1111", rdy); end
            xa = 16'($urandom); xb = 16'($urandom); xi = 1'($urandom);
            a = xa; b = xb; borr_in = xi; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom);
            got = '0;
            c = 0;
            while (got !== 4'hF && c < 40) begin
                @(posedge clk); #1;
                c++;
                for (int i = 0; i < 4; i++) begin
                    if (!got[i] && vld[i]) begin
                        got[i] = 1'b1;
                        ref_sub(ws[i], xa, xb, xi, ed, eb);
                        case (i)
                            0: begin dsel = {8'h00, df0}; bsel = brw0; zsel = zr0; end
                            1: begin dsel = {8'h00, df1}; bsel = brw1; zsel = zr1; end
                            2: begin dsel = {8'h00, df2}; bsel = brw2; zsel = zr2; end
                            default: begin dsel = df3; bsel = brw3; zsel = zr3; end
                        endcase
                        tests++;
                        if (c !== ns[i]) begin fails++; $display("FAIL sweep_latency%0d got %0d want %0d", i, c, ns[i]); end
                        tests++;
                        if (dsel !== ed || bsel !== eb) begin
                            fails++;
                            $display("FAIL sweep_result%0d a=%h b=%h bi=%b got diff=%h borr=%b want diff=%h borr=%b",
                                     i, xa, xb, xi, dsel, bsel, ed, eb);
                        end
                        tests++;
                        if (zsel !== (ed == 16'h0000)) begin
                            fails++; $display("FAIL sweep_zero%0d got %b want %b", i, zsel, ed == 16'h0000);
                        end
                    end
                end
            end
            tests++;
            if (got !== 4'hF) begin fails++; $display("FAIL sweep_timeout got done=%b want 1111", got); end
            @(posedge clk);
        end
    endtask

    task automatic test_backpressure();
        int n;
        @(negedge clk);
        a = 16'h005A; b = 16'h003C; borr_in = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            if (vld0 === 1'b1) break;
            a = 16'($urandom); b = 16'($urandom); in_valid = 1'($urandom); borr_in = 1'($urandom);
            n++;
        end
        tests++;
        if (vld0 !== 1'b1) begin fails++; $display("FAIL bp_done got vld=%b want 1", vld0); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a = 16'($urandom); b = 16'($urandom); in_valid = 1'($urandom); borr_in = 1'($urandom);
            @(posedge clk); #1;
            tests++;
            if (vld0 !== 1'b1 || rdy0 !== 1'b0 || df0 !== 8'h1D || brw0 !== 1'b0 || zr0 !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold%0d got vld=%b rdy=%b diff=%h borr=%b zero=%b want vld=1 rdy=0 diff=1d borr=0 zero=0",
                         i, vld0, rdy0, df0, brw0, zr0);
            end
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (rdy0 !== 1'b1 || vld0 !== 1'b0) begin
            fails++; $display("FAIL bp_release got rdy=%b vld=%b want rdy=1 vld=0", rdy0, vld0);
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        @(negedge clk);
        a = 16'h0080; b = 16'h0001; borr_in = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        tests++;
        if (rdy0 !== 1'b1 || vld0 !== 1'b0 || df0 !== 8'h00) begin
            fails++; $display("FAIL midreset_async got rdy=%b vld=%b diff=%h want rdy=1 vld=0 diff=00", rdy0, vld0, df0);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (vld0 === 1'b1) seen = 1'b1;
        end
        tests++;
        if (seen !== 1'b0) begin fails++; $display("FAIL midreset_stale got out_valid seen=%b want 0", seen); end
        run_main(8'h10, 8'h01, 1'b0, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [7:0]  qa[4], qb[4];
        logic        qi[4];
        logic [15:0] ed[4];
        logic        eb[4];
        int          acc[4];
        int          na, nr, cyc;
        logic        pr, pv, pin, pb, pz, seen;
        logic [7:0]  pd;
        for (int i = 0; i < 4; i++) begin
            qa[i] = 8'($urandom); qb[i] = 8'($urandom); qi[i] = 1'($urandom);
            ref_sub(8, {8'h00, qa[i]}, {8'h00, qb[i]}, qi[i], ed[i], eb[i]);
        end
        na = 0; nr = 0; cyc = 0;
        out_ready = 1'b1;
        while (nr < 4 && cyc < 200) begin
            @(negedge clk);
            if (na < 4) begin
                in_valid = 1'b1; a = {8'h00, qa[na]}; b = {8'h00, qb[na]}; borr_in = qi[na];
            end else begin
                in_valid = 1'b0;
            end
            pr = rdy0; pv = vld0; pd = df0; pb = brw0; pz = zr0; pin = in_valid;
            @(posedge clk);
            cyc++;
            if (pr && pin) begin
                acc[na] = cyc;
                na++;
            end
            if (pv) begin
                tests++;
                if (pd !== ed[nr][7:0] || pb !== eb[nr] || pz !== (ed[nr][7:0] == 8'h00)) begin
                    fails++;
                    $display("FAIL b2b_result%0d got diff=%h borr=%b zero=%b want diff=%h borr=%b zero=%b",
                             nr, pd, pb, pz, ed[nr][7:0], eb[nr], ed[nr][7:0] == 8'h00);
                end
                nr++;
            end
        end
        in_valid = 1'b0;
        tests++;
        if (na !== 4 || nr !== 4) begin fails++; $display("FAIL b2b_count got accepts=%0d results=%0d want 4 and 4", na, nr); end
        for (int i = 1; i < 4; i++) begin
            if (i < na) begin
                tests++;
                if (acc[i] - acc[i-1] !== 10) begin
                    fails++; $display("FAIL b2b_spacing%0d got %0d want 10", i, acc[i] - acc[i-1]);
                end
            end
        end
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (vld0 === 1'b1) seen = 1'b1;
        end
        tests++;
        if (seen !== 1'b0) begin fails++; $display("FAIL b2b_extra got out_valid seen=%b want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_sweep();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
